// File: rtl/scmp_bus_ctl.sv
// SC/MP external bus cycle sequencer: arbitration, address strobe, data strobe with wait states, release.
// Owns the BREQ/ENIN/ENOUT daisy chain and stalls the microcode sequencer until the cycle completes.
module scmp_bus_ctl #(
   parameter int ADS_CYCLES  = 1,
   parameter int DATA_CYCLES = 2,
   parameter int HOLD_MAX    = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mc_ads,
   input  logic       mc_rd,
   input  logic       mc_wr,
   input  logic [3:0] mc_flags,
   output logic       mc_stall,
   output logic       data_latch,
   output logic       bus_timeout,
   input  logic       bus_ENIN,
   output logic       bus_ENOUT,
   output logic       bus_BREQ,
   input  logic       bus_HOLD,
   output logic       bus_ADS_n,
   output logic       bus_RD_n,
   output logic       bus_WR_n,
   output logic       bus_F_R,
   output logic       bus_F_I,
   output logic       bus_F_D,
   output logic       bus_F_H,
   output logic       bus_drv_en
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_ADDR,
      S_DATA,
      S_DONE
   } state_t;

   localparam logic [2:0] ADS_LOAD = 3'(ADS_CYCLES);
   localparam logic [3:0] DAT_LOAD = 4'(DATA_CYCLES);
   localparam bit         HOLD_EN  = (HOLD_MAX > 0);
   localparam logic [7:0] HOLD_LIM = 8'(HOLD_EN ? HOLD_MAX - 1 : 0);

   state_t     state;
   state_t     state_nxt;
   logic [2:0] ads_cnt;
   logic [3:0] dat_cnt;
   logic [7:0] hold_cnt;
   logic       typ_rd;
   logic       typ_wr;
   logic [3:0] flags_q;

   logic       dat_last;
   logic       hold_hit;

   assign dat_last = (dat_cnt <= 4'd1);
   // Timeout fires in the DATA cycle whose hold increment would reach the limit.
   assign hold_hit = HOLD_EN && (dat_cnt == 4'd0) && bus_HOLD && (hold_cnt == HOLD_LIM);

   assign bus_ENOUT = bus_ENIN & (state == S_IDLE) & ~mc_ads & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         ads_cnt  <= '0;
         dat_cnt  <= '0;
         hold_cnt <= '0;
         typ_rd   <= 1'b0;
         typ_wr   <= 1'b0;
         flags_q  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (mc_ads) begin
                  typ_rd  <= mc_rd;
                  typ_wr  <= mc_wr & ~mc_rd;
                  flags_q <= mc_flags;
               end
            end
            S_ARB: begin
               if (bus_ENIN) ads_cnt <= ADS_LOAD;
            end
            S_ADDR: begin
               if (ads_cnt != 3'd0) ads_cnt <= ads_cnt - 3'd1;
               dat_cnt  <= DAT_LOAD;
               hold_cnt <= '0;
            end
            S_DATA: begin
               if (dat_cnt != 4'd0) dat_cnt <= dat_cnt - 4'd1;
               if ((dat_cnt == 4'd0) && bus_HOLD && (hold_cnt != 8'hFF))
                  hold_cnt <= hold_cnt + 8'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt   = state;
      mc_stall    = 1'b0;
      data_latch  = 1'b0;
      bus_timeout = 1'b0;
      bus_BREQ    = 1'b0;
      bus_ADS_n   = 1'b1;
      bus_RD_n    = 1'b1;
      bus_WR_n    = 1'b1;
      bus_F_R     = 1'b0;
      bus_F_I     = 1'b0;
      bus_F_D     = 1'b0;
      bus_F_H     = 1'b0;
      bus_drv_en  = 1'b0;
      case (state)
         S_IDLE: begin
            mc_stall = mc_ads & ~rst;
            if (mc_ads) state_nxt = S_ARB;
         end
         S_ARB: begin
            bus_BREQ = 1'b1;
            mc_stall = 1'b1;
            if (bus_ENIN) state_nxt = S_ADDR;
         end
         S_ADDR: begin
            bus_ADS_n  = 1'b0;
            bus_drv_en = 1'b1;
            bus_BREQ   = 1'b1;
            mc_stall   = 1'b1;
            bus_F_R    = flags_q[0];
            bus_F_I    = flags_q[1];
            bus_F_D    = flags_q[2];
            bus_F_H    = flags_q[3];
            if (ads_cnt <= 3'd1) state_nxt = (typ_rd | typ_wr) ? S_DATA : S_DONE;
         end
         S_DATA: begin
            bus_RD_n   = ~typ_rd;
            bus_WR_n   = ~typ_wr;
            bus_drv_en = 1'b1;
            bus_BREQ   = 1'b1;
            mc_stall   = 1'b1;
            if (hold_hit) begin
               bus_timeout = 1'b1;
               state_nxt   = S_DONE;
            end else if (dat_last && !bus_HOLD) begin
               data_latch = typ_rd;
               state_nxt  = S_DONE;
            end
         end
         S_DONE: begin
            bus_drv_en = typ_wr;
            state_nxt  = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule
